// File: rtl/gates_mux_sweep_pkg.sv
// Shared definitions for the MUX2X1 sweep checker: FSM states, LFSR constants
// and the exhaustive vector count. The RAND state and the LFSR are only
// meaningful when GATES_SWEEP_RAND_EN is defined.
package gates_mux_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
`ifdef GATES_SWEEP_RAND_EN
    ,
    ST_RAND   = 3'd5
`endif
  } state_e;

  // Seed reloaded at every accepted start so random runs are repeatable.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps for x^8+x^6+x^5+x^4+1 in a left-shifting register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  // Exhaustive (a,b) combinations per sweep.
  localparam int         N_VEC     = 4;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gates_sweep_lfsr.sv
// 8-bit maximal-length LFSR used to generate the random (a,b) tail of a run.
// load_i reloads the seed and wins over step_i; step_i advances one state.
module gates_sweep_lfsr
  import gates_mux_sweep_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       step_i,
  output logic [1:0] bits_o
);

  logic [7:0] lfsr_q;

  // Seed on reset or load, otherwise advance once per requested step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (load_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign bits_o = lfsr_q[1:0];

endmodule

// File: rtl/gates_mux_sweep_checker.sv
// Clocked built-in self-test wrapper for the MUX2X1 gate self-check block.
// Sweeps (a,b) through 00,01,10,11 for N_SWEEPS passes, waits SETTLE_CYC idle
// cycles per vector, samples fail, counts failures (saturating), records the
// first failing vector and reports a verdict with a one-cycle done pulse.
// Optional feature macro: GATES_SWEEP_RAND_EN appends N_RAND LFSR vectors.
//
// Handshake: start is a single-cycle request sampled only in IDLE; busy is
// high from the cycle after acceptance through the DONE cycle; done pulses
// for exactly the DONE cycle and pass/err_cnt/first_fail_* are valid then and
// held until the next accepted start.
module gates_mux_sweep_checker
  import gates_mux_sweep_pkg::*;
#(
  parameter int N_SWEEPS   = 2,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8,
  parameter int N_RAND     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             fail,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_fail_vld,
  output logic [1:0]       first_fail_ab,
  output state_e           dbg_state
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC > 0 ? SETTLE_CYC - 1 : 0);
  localparam logic [7:0] SWEEP_LAST  = 8'(N_SWEEPS - 1);
  localparam logic [1:0] VEC_LAST    = 2'(N_VEC - 1);

  state_e           state_q;
  logic             a_q, b_q, busy_q, done_q, pass_q, ffv_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] err_d;
  logic [1:0]       ffab_q;
  logic [1:0]       vec_q;
  logic [7:0]       sweep_q;
  logic [3:0]       settle_q;
  logic             last_exh;

`ifdef GATES_SWEEP_RAND_EN
  localparam logic [15:0] RAND_LAST = 16'(N_RAND > 0 ? N_RAND - 1 : 0);
  logic        rand_phase_q;
  logic [15:0] rand_cnt_q;
  logic [1:0]  lfsr_bits;
  logic        lfsr_load, lfsr_step;

  assign lfsr_load = (state_q == ST_IDLE) && start;
  assign lfsr_step = (state_q == ST_RAND);

  gates_sweep_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .bits_o (lfsr_bits)
  );
`else
  // N_RAND is only consumed by the random tail; keep it referenced here.
  if (N_RAND < 0) begin : g_n_rand_unused
  end
`endif

  // Saturating error count including the vector being sampled now.
  always_comb begin
    err_d = err_q;
    if (fail && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end
    last_exh = (vec_q == VEC_LAST) && (sweep_q == SWEEP_LAST);
  end

  // Sweep sequencer: single FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      ffv_q        <= 1'b0;
      ffab_q       <= 2'b00;
      vec_q        <= 2'b00;
      sweep_q      <= 8'd0;
      settle_q     <= 4'd0;
`ifdef GATES_SWEEP_RAND_EN
      rand_phase_q <= 1'b0;
      rand_cnt_q   <= 16'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            err_q        <= '0;
            ffv_q        <= 1'b0;
            ffab_q       <= 2'b00;
            vec_q        <= 2'b00;
            sweep_q      <= 8'd0;
`ifdef GATES_SWEEP_RAND_EN
            rand_phase_q <= 1'b0;
            rand_cnt_q   <= 16'd0;
`endif
            state_q      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          {a_q, b_q} <= vec_q;
          settle_q   <= 4'd0;
          state_q    <= (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;
        end
`ifdef GATES_SWEEP_RAND_EN
        ST_RAND: begin
          {a_q, b_q} <= lfsr_bits;
          settle_q   <= 4'd0;
          state_q    <= (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;
        end
`endif
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= ST_SAMPLE;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        ST_SAMPLE: begin
          err_q <= err_d;
          if (fail && !ffv_q) begin
            ffv_q  <= 1'b1;
            ffab_q <= {a_q, b_q};
          end
`ifdef GATES_SWEEP_RAND_EN
          if (rand_phase_q) begin
            rand_cnt_q <= rand_cnt_q + 16'd1;
            if (rand_cnt_q == RAND_LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              state_q <= ST_RAND;
            end
          end else begin
            vec_q <= vec_q + 2'd1;
            if (vec_q == VEC_LAST) sweep_q <= sweep_q + 8'd1;
            if (last_exh && (N_RAND > 0)) begin
              rand_phase_q <= 1'b1;
              state_q      <= ST_RAND;
            end else if (last_exh) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              state_q <= ST_DRIVE;
            end
          end
`else
          vec_q <= vec_q + 2'd1;
          if (vec_q == VEC_LAST) sweep_q <= sweep_q + 8'd1;
          if (last_exh) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= ST_DRIVE;
          end
`endif
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a              = a_q;
  assign b              = b_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_ab  = ffab_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_gates_mux_sweep_checker.sv
// Directed bench for gates_mux_sweep_checker. Three instances cover
// SETTLE_CYC=1 (default), SETTLE_CYC=0, and a 2-bit saturating counter.
// A behavioural fail source models a correct checker, a checker faulty only
// at {a,b}=10, and a checker stuck failing.
module tb_gates_mux_sweep_checker;
  import gates_mux_sweep_pkg::*;

`ifdef GATES_SWEEP_RAND_EN
  localparam int NR = 16;
`else
  localparam int NR = 0;
`endif

  // Clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   sel = 0;
  int   mode = 0;

  always #5 clk = ~clk;

  logic [2:0] a_w, b_w, busy_w, done_w, pass_w, ffv_w, start_w, fail_w;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [1:0] ffab_w[3];
  state_e     st_w[3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      start_w[i] = start && (sel == i);
      fail_w[i]  = (mode == 2) || ((mode == 1) && a_w[i] && !b_w[i]);
    end
  end

  gates_mux_sweep_checker #(.N_SWEEPS(2), .SETTLE_CYC(1), .CNT_W(8), .N_RAND(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .fail(fail_w[0]),
    .a(a_w[0]), .b(b_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_cnt(err0), .first_fail_vld(ffv_w[0]), .first_fail_ab(ffab_w[0]),
    .dbg_state(st_w[0]));

  gates_mux_sweep_checker #(.N_SWEEPS(2), .SETTLE_CYC(0), .CNT_W(8), .N_RAND(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .fail(fail_w[1]),
    .a(a_w[1]), .b(b_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_cnt(err1), .first_fail_vld(ffv_w[1]), .first_fail_ab(ffab_w[1]),
    .dbg_state(st_w[1]));

  gates_mux_sweep_checker #(.N_SWEEPS(1), .SETTLE_CYC(0), .CNT_W(2), .N_RAND(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .fail(fail_w[2]),
    .a(a_w[2]), .b(b_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_cnt(err2), .first_fail_vld(ffv_w[2]), .first_fail_ab(ffab_w[2]),
    .dbg_state(st_w[2]));

  // Observation mux onto the instance under test
  logic       o_a, o_b, o_busy, o_done, o_pass, o_ffv;
  logic [1:0] o_ffab;
  logic [7:0] o_err;
  state_e     o_st;

  always_comb begin
    o_a    = a_w[sel];
    o_b    = b_w[sel];
    o_busy = busy_w[sel];
    o_done = done_w[sel];
    o_pass = pass_w[sel];
    o_ffv  = ffv_w[sel];
    o_ffab = ffab_w[sel];
    o_st   = st_w[sel];
    o_err  = (sel == 0) ? err0 : (sel == 1) ? err1 : {6'd0, err2};
  end

  // Scoreboard
  int         checks = 0;
  int         errors = 0;
  int         done_pulses = 0;
  logic [1:0] exp_q[$];

  always @(posedge clk) if (o_done) done_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: reset
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Driver: one full run with optional start re-pulses at cycles re1/re2
  task automatic run(input int nsw, input int settle, input int cmax,
                     input int re1, input int re2);
    logic [1:0] vecs[$];
    logic [7:0] l;
    int         exp_err, cyc, n_samp;
    logic       exp_ffv, f;
    logic [1:0] exp_ffab;
    for (int s = 0; s < nsw; s++)
      for (int v = 0; v < 4; v++) vecs.push_back(2'(v));
    l = 8'hA5;
    for (int r = 0; r < NR; r++) begin
      vecs.push_back(l[1:0]);
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    exp_err = 0;
    exp_ffv = 1'b0;
    exp_ffab = 2'b00;
    exp_q.delete();
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i]);
      f = (mode == 2) || ((mode == 1) && (vecs[i] == 2'b10));
      if (f) begin
        if (exp_err < cmax) exp_err++;
        if (!exp_ffv) begin
          exp_ffv = 1'b1;
          exp_ffab = vecs[i];
        end
      end
    end
    done_pulses = 0;
    n_samp = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    check("busy_after_accept", o_busy, 1);
    while (!o_done && cyc < 400) begin
      start = (cyc == re1) || (cyc == re2);
      if (o_st == ST_SAMPLE) begin
        n_samp++;
        if (exp_q.size() > 0) check("vector_at_sample", {o_a, o_b}, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("run_length", cyc, 1 + (4 * nsw + NR) * (2 + settle));
    check("sample_count", n_samp, vecs.size());
    check("err_cnt", o_err, exp_err);
    check("pass", o_pass, exp_err == 0);
    check("first_fail_vld", o_ffv, exp_ffv);
    check("first_fail_ab", o_ffab, exp_ffab);
    @(posedge clk);
    #1;
    check("done_one_cycle", o_done, 0);
    check("busy_falls", o_busy, 0);
    check("done_pulse_count", done_pulses, 1);
    check("ab_hold", {o_a, o_b}, vecs[vecs.size() - 1]);
  endtask

  initial begin
    do_reset();
    check("rst_a", o_a, 0);
    check("rst_b", o_b, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_pass", o_pass, 0);
    check("rst_err", o_err, 0);
    check("rst_ffv", o_ffv, 0);
    check("rst_ffab", o_ffab, 0);
    check("rst_state", 32'(o_st), 32'(ST_IDLE));

    // Correct checker
    sel = 0; mode = 0;
    run(2, 1, 255, -1, -1);
    repeat (3) @(posedge clk);
    #1;
    check("pass_held_idle", o_pass, 1);

    // Checker faulty only at {a,b}=10
    mode = 1;
    run(2, 1, 255, -1, -1);

    // start re-pulsed while busy is ignored
    mode = 0;
    run(2, 1, 255, 3, 10);

    // Reset mid-run at cycle 7 with a stuck-failing checker
    mode = 2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("err_before_reset", o_err, 2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_a", o_a, 0);
    check("midrst_b", o_b, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_pass", o_pass, 0);
    check("midrst_err", o_err, 0);
    check("midrst_ffv", o_ffv, 0);
    check("midrst_state", 32'(o_st), 32'(ST_IDLE));
    mode = 0;
    run(2, 1, 255, -1, -1);

    // SETTLE_CYC=0, fail stuck high
    sel = 1; mode = 2;
    run(2, 0, 255, -1, -1);

    // 2-bit counter saturation
    sel = 2; mode = 2;
    run(1, 0, 3, -1, -1);

    // Second random-tail run must replay the same sequence
    sel = 0; mode = 2;
    run(2, 1, 255, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
